control_timer: RTL and testbench

Front-end controller for the countdown timer. It turns a 10-key one-hot keypad into a registered BCD digit `d` and a one-cycle active-low load strobe `loadn` for the downstream digit/counter chain. It also divides the system clock into the 1 Hz square wave `pgt_1Hz` (positive-going-transition clock) that paces the countdown. It sits between the keypad/switch inputs and the timer counter datapath.

---
 rtl/control_timer.sv | 144 ++++++++++++++
 tb/tb_control_timer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_timer.sv
// Keypad front end for the countdown timer: priority-encodes a one-hot keypad into a
// BCD digit with a one-cycle active-low load strobe, and divides clk into pgt_1Hz.
// Optional key debounce filter is enabled by defining CONTROL_TIMER_DEBOUNCE_EN.
module control_timer #(
  parameter int CLK_DIV         = 100,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keyboard,
  input  logic       enablen,
  output logic [3:0] d,
  output logic       loadn,
  output logic       pgt_1Hz
);

  localparam logic [3:0] CODE_NONE = 4'hF;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  // Illegal configurations are rejected at elaboration.
  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0) || (DEBOUNCE_CYCLES < 1)) begin : g_bad_cfg
    $error("control_timer: CLK_DIV must be even and >= 2, DEBOUNCE_CYCLES >= 1");
  end

  // Highest pressed key wins; CODE_NONE when no key is down.
  function automatic logic [3:0] encode_key(input logic [9:0] keys);
    logic [3:0] code;
    code = CODE_NONE;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) begin
        code = 4'(i);
      end
    end
    return code;
  endfunction

  logic [3:0]       w_raw_code;
  logic [3:0]       w_code;
  logic             w_accept;
  logic [3:0]       r_prev_code;
  logic [3:0]       r_d;
  logic             r_loadn;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_next;
  logic             r_pgt;

  assign w_raw_code = encode_key(keyboard);

`ifdef CONTROL_TIMER_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);

  logic [3:0]      r_db_cand;
  logic [3:0]      r_db_filt;
  logic [DB_W-1:0] r_db_cnt;
  logic [DB_W-1:0] w_db_cnt_next;

  // Run length of the current raw code, saturating at the stability window.
  always_comb begin
    w_db_cnt_next = r_db_cnt;
    if (w_raw_code != r_db_cand) begin
      w_db_cnt_next = DB_W'(1);
    end else if (r_db_cnt != DB_LAST) begin
      w_db_cnt_next = r_db_cnt + DB_W'(1);
    end else begin
      w_db_cnt_next = r_db_cnt;
    end
  end

  // Filtered code follows the raw code only once it has been stable for the whole window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cand <= CODE_NONE;
      r_db_cnt  <= {DB_W{1'b0}};
      r_db_filt <= CODE_NONE;
    end else begin
      r_db_cand <= w_raw_code;
      r_db_cnt  <= w_db_cnt_next;
      if (w_db_cnt_next == DB_LAST) begin
        r_db_filt <= w_raw_code;
      end
    end
  end

  assign w_code = r_db_filt;
`else
  assign w_code = w_raw_code;
`endif

  // A key is accepted only when it is new relative to the last sampled code.
  always_comb begin
    w_accept = 1'b0;
    if (!enablen && (w_code != CODE_NONE) && (w_code != r_prev_code)) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
  end

  // prev_code tracks the code every cycle, so keys held while disabled count as seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_code <= CODE_NONE;
      r_d         <= 4'd0;
      r_loadn     <= 1'b1;
    end else begin
      r_prev_code <= w_code;
      if (w_accept) begin
        r_d     <= w_code;
        r_loadn <= 1'b0;
      end else begin
        r_loadn <= 1'b1;
      end
    end
  end

  // Free-running divider count.
  always_comb begin
    w_div_next = r_div_cnt;
    if (r_div_cnt == DIV_LAST) begin
      w_div_next = {DIV_W{1'b0}};
    end else begin
      w_div_next = r_div_cnt + DIV_W'(1);
    end
  end

  // pgt_1Hz is decoded from the next count so it stays aligned with div_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= {DIV_W{1'b0}};
      r_pgt     <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_pgt     <= (w_div_next >= DIV_HALF);
    end
  end

  assign d       = r_d;
  assign loadn   = r_loadn;
  assign pgt_1Hz = r_pgt;

endmodule

// File: tb/tb_control_timer.sv
// Self-checking bench for control_timer: directed steps followed by random key traffic,
// compared every cycle against a behavioural model of the accept and divider rules.
module tb_control_timer;

  localparam int CLK_DIV = 100;
  localparam int DB_CYC  = 4;
`ifdef CONTROL_TIMER_DEBOUNCE_EN
  localparam int LAT = DB_CYC + 1;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] keyboard = 10'd0;
  logic       enablen = 1'b1;
  logic [3:0] d;
  logic       loadn;
  logic       pgt_1Hz;

  int checks = 0;
  int failures = 0;

  // model state: codes are -1 for "no key"
  int   md = 0;
  int   mprev = -1;
  int   mfilt = -1;
  int   t = 0;
  logic mload = 1'b1;
  logic mpgt = 1'b0;
  int   hist[$];

  int   rises[$];
  int   falls[$];
  logic last_pgt = 1'b0;
  int   ph_pulses = 0;
  int   ph_ticks = 0;
  int   first_pulse = -1;

  control_timer #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CYCLES(DB_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .keyboard (keyboard),
    .enablen  (enablen),
    .d        (d),
    .loadn    (loadn),
    .pgt_1Hz  (pgt_1Hz)
  );

  always #5 clk = ~clk;

  function automatic int prio(input logic [9:0] k);
    int r = -1;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) r = i;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_edge();
    int raw;
    int code;
`ifdef CONTROL_TIMER_DEBOUNCE_EN
    int same;
`endif
    if (rst) begin
      md = 0; mload = 1'b1; mprev = -1; mfilt = -1; t = 0;
      hist.delete();
    end else begin
      raw = prio(keyboard);
`ifdef CONTROL_TIMER_DEBOUNCE_EN
      code = mfilt;
      hist.push_back(raw);
      if (hist.size() > DB_CYC) void'(hist.pop_front());
      if (hist.size() == DB_CYC) begin
        same = 1;
        foreach (hist[i]) if (hist[i] != raw) same = 0;
        if (same == 1) mfilt = raw;
      end
`else
      code = raw;
`endif
      if (!enablen && code >= 0 && code != mprev) begin
        md = code; mload = 1'b0;
      end else begin
        mload = 1'b1;
      end
      mprev = code;
      t++;
    end
    mpgt = ((t % CLK_DIV) >= (CLK_DIV / 2));
  endtask

  task automatic tick(input logic r, input logic [9:0] kb, input logic en);
    rst = r; keyboard = kb; enablen = en;
    @(posedge clk);
    model_edge();
    #1;
    chk("d", 32'(d), 32'(md));
    chk("loadn", 32'(loadn), 32'(mload));
    chk("pgt_1Hz", 32'(pgt_1Hz), 32'(mpgt));
    if (pgt_1Hz === 1'b1 && last_pgt === 1'b0) rises.push_back(t);
    if (pgt_1Hz === 1'b0 && last_pgt === 1'b1) falls.push_back(t);
    last_pgt = pgt_1Hz;
    ph_ticks++;
    if (loadn === 1'b0) begin
      ph_pulses++;
      if (first_pulse < 0) first_pulse = ph_ticks;
    end
  endtask

  task automatic run(input logic [9:0] kb, input logic en, input int n);
    for (int i = 0; i < n; i++) tick(1'b0, kb, en);
  endtask

  task automatic begin_phase();
    ph_pulses = 0; ph_ticks = 0; first_pulse = -1;
  endtask

  initial begin
    logic [9:0] kb;
    logic       en;
    int         hold;
    int         sel;
    int         found;

    // reset and idle: divider timing from reset release
    tick(1'b1, 10'd0, 1'b0);
    tick(1'b1, 10'd0, 1'b0);
    chk("reset_d", 32'(d), 32'd0);
    chk("reset_loadn", 32'(loadn), 32'd1);
    chk("reset_pgt", 32'(pgt_1Hz), 32'd0);
    rises.delete(); falls.delete(); last_pgt = pgt_1Hz;
    begin_phase();
    run(10'd0, 1'b0, 200);
    chk("idle_pulses", 32'(ph_pulses), 32'd0);
    chk("idle_d", 32'(d), 32'd0);
    chk("rise_count", 32'(rises.size()), 32'd2);
    chk("rise0", 32'(rises[0]), 32'd50);
    chk("rise1", 32'(rises[1]), 32'd150);
    chk("fall0", 32'(falls[0]), 32'd100);

    // key 9 held: exactly one strobe
    begin_phase();
    run(10'b1000000000, 1'b0, 100);
    chk("hold9_pulses", 32'(ph_pulses), 32'd1);
    chk("hold9_latency", 32'(first_pulse), 32'(LAT));
    chk("hold9_d", 32'(d), 32'd9);

    // direct change to key 8
    begin_phase();
    run(10'b0100000000, 1'b0, 10);
    chk("chg8_pulses", 32'(ph_pulses), 32'd1);
    chk("chg8_d", 32'(d), 32'd8);

    // disable while held, re-enable: no strobe
    begin_phase();
    run(10'b0100000000, 1'b1, 100);
    run(10'b0100000000, 1'b0, 20);
    chk("reen_pulses", 32'(ph_pulses), 32'd0);
    chk("reen_d", 32'(d), 32'd8);
    begin_phase();
    run(10'd0, 1'b0, 10);
    run(10'b0000001000, 1'b0, 10);
    chk("key3_pulses", 32'(ph_pulses), 32'd1);
    chk("key3_d", 32'(d), 32'd3);

    // priority encode, then reset during the strobe
    run(10'd0, 1'b0, 10);
    found = 0;
    for (int i = 0; i < LAT + 5 && found == 0; i++) begin
      tick(1'b0, 10'b1000000001, 1'b0);
      if (loadn === 1'b0) found = 1;
    end
    chk("prio_strobe_seen", 32'(found), 32'd1);
    chk("prio_d", 32'(d), 32'd9);
    tick(1'b1, 10'b1000000001, 1'b0);
    chk("rst_strobe_loadn", 32'(loadn), 32'd1);
    chk("rst_strobe_d", 32'(d), 32'd0);
    run(10'd0, 1'b0, 10);

`ifdef CONTROL_TIMER_DEBOUNCE_EN
    // short glitch ignored, stable press accepted after the window
    begin_phase();
    run(10'b0000100000, 1'b0, 2);
    run(10'd0, 1'b0, 10);
    chk("glitch_pulses", 32'(ph_pulses), 32'd0);
    begin_phase();
    run(10'b0000100000, 1'b0, 6);
    run(10'd0, 1'b0, 5);
    chk("db_pulses", 32'(ph_pulses), 32'd1);
    chk("db_latency", 32'(first_pulse), 32'd5);
    chk("db_d", 32'(d), 32'd5);
`endif

    // random key traffic against the model
    hold = 0; kb = 10'd0; en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 3) kb = 10'd0;
        else if (sel < 8) kb = 10'd1 << $urandom_range(0, 9);
        else kb = 10'($urandom_range(0, 1023));
        en = ($urandom_range(0, 7) == 0);
        hold = $urandom_range(2, 8);
      end
      tick(($urandom_range(0, 499) == 0), kb, en);
      hold--;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
